// File: rtl/cmp_pkg.sv
// Shared definitions for the signed comparator and its consumers:
// operand sizing, the search FSM states and the {g,l,e} verdict encoding.
package cmp_pkg;

  localparam int WIDTH    = 16;
  localparam int ITER_MAX = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_EVAL,
    S_DONE
  } state_e;

  typedef logic [2:0] verdict_t;

  localparam verdict_t V_GT = 3'b100;
  localparam verdict_t V_LT = 3'b010;
  localparam verdict_t V_EQ = 3'b001;

endpackage

// File: rtl/cmp_verdict_decode.sv
// Decodes a raw {g,l,e} comparator verdict into one-hot flags; anything that
// is not exactly one of the three legal codes is reported as bad.
module cmp_verdict_decode
  import cmp_pkg::*;
(
  input  verdict_t verdict_i,
  output logic     gt_o,
  output logic     lt_o,
  output logic     eq_o,
  output logic     bad_o
);

  always_comb begin
    gt_o  = (verdict_i == V_GT);
    lt_o  = (verdict_i == V_LT);
    eq_o  = (verdict_i == V_EQ);
    bad_o = !(gt_o || lt_o || eq_o);
  end

endmodule

// File: rtl/cmp_search16.sv
// Binary-search engine: drives probe onto comparator B, narrows a signed
// [lo,hi] interval from the comparator verdicts and reports the located A.
module cmp_search16
  import cmp_pkg::*;
#(
  parameter int WIDTH    = cmp_pkg::WIDTH,
  parameter int ITER_MAX = cmp_pkg::ITER_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_g,
  input  logic             cmp_l,
  input  logic             cmp_e,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       iter
);

  localparam logic [4:0] ITER_LAST = 5'(ITER_MAX);

  // One extra bit so lo can step past the top and hi past the bottom of range.
  localparam logic signed [WIDTH:0] LO_INIT = {2'b11, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH:0] HI_INIT = {2'b00, {(WIDTH-1){1'b1}}};

  state_e                  state_q;
  logic signed [WIDTH:0]   lo_q, hi_q;
  logic [WIDTH-1:0]        probe_q, result_q;
  logic                    busy_q, done_q, found_q, err_q;
  logic [4:0]              iter_q;

  logic [WIDTH-1:0]        probe_d;
  logic signed [WIDTH:0]   lo_inc_d, hi_dec_d;
  logic                    v_gt, v_lt, v_eq, v_bad;

  cmp_verdict_decode u_decode (
    .verdict_i ({cmp_g, cmp_l, cmp_e}),
    .gt_o      (v_gt),
    .lt_o      (v_lt),
    .eq_o      (v_eq),
    .bad_o     (v_bad)
  );

  // Midpoint floors toward -inf; lo+hi always fits WIDTH+1 bits while lo<=hi.
  always_comb begin
    probe_d  = WIDTH'((lo_q + hi_q) >>> 1);
    lo_inc_d = {probe_q[WIDTH-1], probe_q} + (WIDTH+1)'(1);
    hi_dec_d = {probe_q[WIDTH-1], probe_q} - (WIDTH+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      probe_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      iter_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            lo_q     <= LO_INIT;
            hi_q     <= HI_INIT;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            iter_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (iter_q == ITER_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            probe_q <= probe_d;
            iter_q  <= iter_q + 5'd1;
            state_q <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (v_eq) begin
            result_q <= probe_q;
            found_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (v_gt) begin
            lo_q <= lo_inc_d;
            if (lo_inc_d > hi_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_SETUP;
            end
          end else if (v_lt) begin
            hi_q <= hi_dec_d;
            if (lo_q > hi_dec_d) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_SETUP;
            end
          end else begin
            err_q   <= v_bad;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign probe  = probe_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;
  assign iter   = iter_q;

endmodule

// File: tb/tb_cmp_search16.sv
// Bench for cmp_search16: a behavioural comparator on A=target (with fault
// injection), a reference search model feeding expected-result/probe queues.
module tb_cmp_search16;

  localparam int W = 16;

  logic         clk, rst, start;
  logic         cmp_g, cmp_l, cmp_e;
  logic [W-1:0] probe, result;
  logic         busy, done, found, err;
  logic [4:0]   iter;

  int           target;
  int           fault_iter;   // 0: none, 99: every EVAL, n: nth EVAL only
  logic [2:0]   fault_pat;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       found;
    logic       err;
    logic [W-1:0] result;
    logic [4:0] iter;
    logic [7:0] lat;
  } exp_t;

  exp_t exp_q[$];
  int   probe_q[$];

  cmp_search16 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_g  (cmp_g),
    .cmp_l  (cmp_l),
    .cmp_e  (cmp_e),
    .probe  (probe),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result),
    .iter   (iter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (fault_iter == 99 || (fault_iter != 0 && int'(iter) == fault_iter)) begin
      {cmp_g, cmp_l, cmp_e} = fault_pat;
    end else begin
      cmp_g = (target > int'($signed(probe)));
      cmp_l = (target < int'($signed(probe)));
      cmp_e = (target == int'($signed(probe)));
    end
  end

  // Reference binary search over plain ints.
  function automatic exp_t model(input int tgt, input int fi, input logic [2:0] fp);
    exp_t e;
    int lo, hi, n, p;
    logic [2:0] v;
    bit sat;
    e = '0; lo = -32768; hi = 32767; n = 0; sat = 0;
    while (1) begin
      if (n == 17) begin e.err = 1'b1; sat = 1; break; end
      p = (lo + hi) >>> 1;
      probe_q.push_back(p);
      n++;
      if (fi == 99 || fi == n) v = fp;
      else v = {tgt > p, tgt < p, tgt == p};
      if (v == 3'b001) begin e.found = 1'b1; e.result = p[W-1:0]; break; end
      else if (v == 3'b100) begin lo = p + 1; if (lo > hi) break; end
      else if (v == 3'b010) begin hi = p - 1; if (lo > hi) break; end
      else begin e.err = 1'b1; break; end
    end
    e.iter = 5'(n);
    e.lat  = sat ? 8'(2 * n + 2) : 8'(2 * n + 1);
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (probe !== '0)  begin errors++; $display("FAIL reset.probe: got %0h want 0", probe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset.busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset.done: got %b want 0", done); end
    checks++; if ({found, err} !== 2'b00) begin errors++; $display("FAIL reset.flags: got %b want 00", {found, err}); end
    checks++; if ({result, iter} !== '0) begin errors++; $display("FAIL reset.result_iter: got %0h/%0d want 0/0", result, iter); end
    rst = 1'b0;
  endtask

  task automatic run_search(input string name, input int tgt, input int fi, input logic [2:0] fp);
    exp_t e;
    int cyc, last_iter, pexp;
    target = tgt; fault_iter = fi; fault_pat = fp;
    probe_q.delete();
    exp_q.push_back(model(tgt, fi, fp));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s.busy_after_start: got %b want 1", name, busy); end
    cyc = 0; last_iter = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (int'(iter) != last_iter) begin
        last_iter = int'(iter);
        checks++;
        if (probe_q.size() == 0) begin
          errors++; $display("FAIL %s.probe_extra: got %0d want none", name, $signed(probe));
        end else begin
          pexp = probe_q.pop_front();
          if (int'($signed(probe)) !== pexp) begin
            errors++; $display("FAIL %s.probe%0d: got %0d want %0d", name, last_iter, $signed(probe), pexp);
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL %s.timeout: got no done want done within 60 cycles", name);
      return;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s.busy_with_done: got %b want 0", name, busy); end
    checks++; if (found !== e.found) begin errors++; $display("FAIL %s.found: got %b want %b", name, found, e.found); end
    checks++; if (err !== e.err) begin errors++; $display("FAIL %s.err: got %b want %b", name, err, e.err); end
    checks++; if (result !== e.result) begin errors++; $display("FAIL %s.result: got %0d want %0d", name, $signed(result), $signed(e.result)); end
    checks++; if (iter !== e.iter) begin errors++; $display("FAIL %s.iter: got %0d want %0d", name, iter, e.iter); end
    checks++; if (8'(cyc + 1) !== e.lat) begin errors++; $display("FAIL %s.latency: got %0d want %0d", name, cyc + 1, e.lat); end
    checks++; if (probe_q.size() != 0) begin errors++; $display("FAIL %s.probes_missing: got %0d left want 0", name, probe_q.size()); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s.done_pulse: got %b want 0", name, done); end
    checks++; if (found !== e.found || iter !== e.iter) begin
      errors++; $display("FAIL %s.held: got found=%b iter=%0d want found=%b iter=%0d", name, found, iter, e.found, e.iter);
    end
    fault_iter = 0;
  endtask

  task automatic test_found_values();
    run_search("neg_one", -1, 0, 3'b000);
    run_search("max_pos", 32767, 0, 3'b000);
    run_search("min_neg", -32768, 0, 3'b000);
    run_search("zero", 0, 0, 3'b000);
    for (int i = 0; i < 6; i++) run_search("random", int'($urandom_range(0, 65535)) - 32768, 0, 3'b000);
  endtask

  task automatic test_bad_verdicts();
    run_search("zero_verdict_3rd", 1000, 3, 3'b000);
    run_search("double_verdict_1st", 1000, 1, 3'b110);
    run_search("always_gt_empty", 0, 99, 3'b100);
  endtask

  task automatic test_reset_abort();
    bit seen_done;
    target = 1000; fault_iter = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({probe, busy, done, found, err, result, iter} !== '0) begin
      errors++; $display("FAIL abort.outputs: got probe=%0h busy=%b done=%b found=%b err=%b result=%0h iter=%0d want all 0",
                         probe, busy, done, found, err, result, iter);
    end
    rst = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1;
    end
    checks++; if (seen_done) begin errors++; $display("FAIL abort.no_done: got activity want idle"); end
    run_search("restart_1000", 1000, 0, 3'b000);
  endtask

  task automatic test_start_held();
    exp_t e;
    int cyc;
    target = 5; fault_iter = 0;
    e = model(5, 0, 3'b000);
    probe_q.delete();
    @(posedge clk); #1 start = 1'b1;
    cyc = 0;
    @(posedge clk); #1;
    while (done !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL held.timeout: got no done want done");
      start = 1'b0;
      return;
    end
    checks++; if (result !== e.result || iter !== e.iter) begin
      errors++; $display("FAIL held.first: got result=%0d iter=%0d want %0d/%0d", $signed(result), iter, $signed(e.result), e.iter);
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || found !== 1'b1) begin
      errors++; $display("FAIL held.done_cycle_ignored: got busy=%b found=%b want 0/1", busy, found);
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || found !== 1'b0 || iter !== 5'd0) begin
      errors++; $display("FAIL held.restart: got busy=%b found=%b iter=%0d want 1/0/0", busy, found, iter);
    end
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (done !== 1'b1 || found !== 1'b1 || result !== 16'd5) begin
      errors++; $display("FAIL held.second: got done=%b found=%b result=%0d want 1/1/5", done, found, $signed(result));
    end
  endtask

  initial begin
    start = 1'b0; rst = 1'b1;
    target = 0; fault_iter = 0; fault_pat = 3'b000;
    test_reset();
    test_found_values();
    test_bad_verdicts();
    test_reset_abort();
    test_start_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
